// File: rtl/mux41_scan_sequencer.sv
// rtl/mux41_scan_sequencer.sv - drives a 4:1 mux through all selects, samples c, reassembles and checks the word
module mux41_scan_sequencer #(
    parameter int unsigned DWELL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] word_in,
    input  logic       word_valid,
    output logic       word_ready,
    output logic [3:0] a,
    output logic [1:0] s,
    input  logic       c,
    output logic       serial_out,
    output logic       serial_valid,
    output logic [3:0] word_out,
    output logic       frame_done,
    output logic       mismatch
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [2:0] cap;

    assign word_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            a            <= 4'd0;
            s            <= 2'd0;
            cnt          <= 4'd0;
            cap          <= 3'd0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            word_out     <= 4'd0;
            frame_done   <= 1'b0;
            mismatch     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (word_valid) begin
                        a     <= word_in;
                        s     <= 2'd0;
                        cnt   <= 4'd0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (cnt == DWELL_LAST) begin
                        serial_out   <= c;
                        serial_valid <= 1'b1;
                        case (s)
                            2'd0: cap[0] <= c;
                            2'd1: cap[1] <= c;
                            2'd2: cap[2] <= c;
                            default: ;
                        endcase
                        if (s != 2'd3) begin
                            s   <= s + 2'd1;
                            cnt <= 4'd0;
                        end else begin
                            // cap[2:0] already holds selects 0..2; c is the select-3 bit
                            word_out   <= {c, cap};
                            mismatch   <= ({c, cap} != a);
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end
                    end else begin
                        cnt          <= cnt + 4'd1;
                        serial_valid <= 1'b0;
                    end
                end
                DONE: begin
                    frame_done   <= 1'b0;
                    serial_valid <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux41_scan_sequencer.sv
// tb/tb_mux41_scan_sequencer.sv - directed checks of the scan sequencer around a behavioural 4:1 mux
module tb_mux41_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       stuck;
    int         n_vec  = 0;
    int         n_miss = 0;

    logic [3:0] word_in;
    logic       word_valid;
    logic       word_ready;
    logic [3:0] a;
    logic [1:0] s;
    logic       c;
    logic       serial_out, serial_valid, frame_done, mismatch;
    logic [3:0] word_out;

    logic [3:0] word_in3;
    logic       word_valid3;
    logic       word_ready3;
    logic [3:0] a3;
    logic [1:0] s3;
    logic       c3;
    logic       serial_out3, serial_valid3, frame_done3, mismatch3;
    logic [3:0] word_out3;

    always #5 clk = ~clk;

    assign c  = stuck ? 1'b0 : a[s];
    assign c3 = a3[s3];

    mux41_scan_sequencer #(.DWELL(1)) dut (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .a(a), .s(s), .c(c),
        .serial_out(serial_out), .serial_valid(serial_valid),
        .word_out(word_out), .frame_done(frame_done), .mismatch(mismatch)
    );

    mux41_scan_sequencer #(.DWELL(3)) dut3 (
        .clk(clk), .rst(rst), .word_in(word_in3), .word_valid(word_valid3),
        .word_ready(word_ready3), .a(a3), .s(s3), .c(c3),
        .serial_out(serial_out3), .serial_valid(serial_valid3),
        .word_out(word_out3), .frame_done(frame_done3), .mismatch(mismatch3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One DWELL=1 frame starting from an IDLE negedge; checks every cycle up to the return to IDLE.
    task automatic frame1(input logic [3:0] w, input bit hold, input bit inject);
        logic [3:0] eb;
        int pulses;
        pulses = 0;
        eb = stuck ? 4'b0000 : w;
        check($sformatf("ready_pre_%h", w), {31'b0, word_ready}, 1);
        word_in    = w;
        word_valid = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (j == 1 && !hold) word_valid = 1'b0;
            if (j == 1 && inject) begin
                word_valid = 1'b1;
                word_in    = 4'hf;
            end
            if (j == 2 && inject) word_valid = 1'b0;
            if (serial_valid) pulses++;
            if (j <= 5) begin
                check($sformatf("s_%h_%0d", w, j), {30'b0, s}, (j <= 4) ? j - 1 : 3);
                check($sformatf("a_%h_%0d", w, j), {28'b0, a}, {28'b0, w});
                check($sformatf("sv_%h_%0d", w, j), {31'b0, serial_valid}, (j >= 2) ? 1 : 0);
                check($sformatf("fd_%h_%0d", w, j), {31'b0, frame_done}, (j == 5) ? 1 : 0);
            end
            if (j >= 2 && j <= 5)
                check($sformatf("so_%h_%0d", w, j), {31'b0, serial_out}, {31'b0, eb[j-2]});
            if (j == 5) begin
                check($sformatf("word_out_%h", w), {28'b0, word_out}, {28'b0, eb});
                check($sformatf("mismatch_%h", w), {31'b0, mismatch}, (eb != w) ? 1 : 0);
            end
            if (j == 6) begin
                check($sformatf("ready_post_%h", w), {31'b0, word_ready}, 1);
                check($sformatf("fd_end_%h", w), {31'b0, frame_done}, 0);
                check($sformatf("sv_end_%h", w), {31'b0, serial_valid}, 0);
                check($sformatf("s_end_%h", w), {30'b0, s}, 3);
            end
        end
        check($sformatf("pulses_%h", w), pulses, 4);
    endtask

    initial begin
        rst = 1'b1; stuck = 1'b0;
        word_in = 4'd0; word_valid = 1'b0;
        word_in3 = 4'd0; word_valid3 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_a", {28'b0, a}, 0);
        check("rst_s", {30'b0, s}, 0);
        check("rst_word_out", {28'b0, word_out}, 0);
        check("rst_flags", {28'b0, serial_out, serial_valid, frame_done, mismatch}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'b0, word_ready}, 1);

        frame1(4'b1010, 1'b0, 1'b0);

        stuck = 1'b1;
        frame1(4'b1111, 1'b0, 1'b0);
        stuck = 1'b0;

        frame1(4'b0001, 1'b0, 1'b1);

        for (int w = 0; w < 16; w++) frame1(4'(w), 1'b1, 1'b0);
        word_valid = 1'b0;
        @(negedge clk);
        check("no_accept_after_hold", {31'b0, word_ready}, 1);

        // reset on the 2nd SCAN cycle aborts the frame
        word_in = 4'b1001; word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_a", {28'b0, a}, 0);
        check("abort_s", {30'b0, s}, 0);
        check("abort_word_out", {28'b0, word_out}, 0);
        check("abort_flags", {28'b0, serial_out, serial_valid, frame_done, mismatch}, 0);
        check("abort_ready", {31'b0, word_ready}, 1);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check($sformatf("abort_no_fd_%0d", j), {31'b0, frame_done}, 0);
        end
        frame1(4'b0011, 1'b0, 1'b0);

        // DWELL=3 instance
        word_in3 = 4'b0110; word_valid3 = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            word_valid3 = 1'b0;
            if (j <= 13) begin
                check($sformatf("d3_s_%0d", j), {30'b0, s3}, (j <= 12) ? (j - 1) / 3 : 3);
                check($sformatf("d3_fd_%0d", j), {31'b0, frame_done3}, (j == 13) ? 1 : 0);
                check($sformatf("d3_sv_%0d", j), {31'b0, serial_valid3},
                      (j == 4 || j == 7 || j == 10 || j == 13) ? 1 : 0);
            end
            if (j == 13) begin
                check("d3_word_out", {28'b0, word_out3}, 32'h6);
                check("d3_mismatch", {31'b0, mismatch3}, 0);
            end
            if (j == 14) check("d3_ready", {31'b0, word_ready3}, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
